// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: multiplier state encoding and sizing constants.
package alu_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_CNT_W = 5;
    localparam logic [MUL_CNT_W-1:0] MUL_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/product valid-ready bundle for the shift-add multiplier.
interface shift_add_multiplier_if;
    import alu_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [MUL_WIDTH-1:0]     a;
    logic [MUL_WIDTH-1:0]     b;
    logic                     out_valid;
    logic                     out_ready;
    logic [2*MUL_WIDTH-1:0]   product;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );

endinterface

// File: rtl/adder32.sv
// Fixed-width 32-bit ripple adder with carry-in and carry-out.
module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c0,
    output logic [31:0] s,
    output logic        carry
);

    assign {carry, s} = {1'b0, a} + {1'b0, b} + {32'd0, c0};

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned 32x32->64 multiplier: one adder32 partial-product add per cycle,
// 32 BUSY cycles, result held in DONE until the consumer takes it.
module shift_add_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    shift_add_multiplier_if.slave  bus
);

    mul_state_t             state;
    logic [WIDTH-1:0]       acc_hi;
    logic [WIDTH-1:0]       acc_lo;
    logic [WIDTH-1:0]       mcand;
    logic [MUL_CNT_W-1:0]   count;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [2*WIDTH-1:0]     product_q;

    logic [WIDTH-1:0]       addend;
    logic [WIDTH-1:0]       sum;
    logic                   c;

    assign addend = mcand & {WIDTH{acc_lo[0]}};

    adder32 u_add (
        .a     (acc_hi),
        .b     (addend),
        .c0    (1'b0),
        .s     (sum),
        .carry (c)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc_hi      <= '0;
            acc_lo      <= '0;
            mcand       <= '0;
            count       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state      <= BUSY;
                        acc_hi     <= '0;
                        acc_lo     <= bus.b;
                        mcand      <= bus.a;
                        count      <= '0;
                        in_ready_q <= 1'b0;
                    end
                end
                BUSY: begin
                    // Carry-out enters the top bit so no product bit is ever lost.
                    acc_hi <= {c, sum[WIDTH-1:1]};
                    acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                    count  <= count + 5'd1;
                    if (count == MUL_LAST) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        product_q   <= {c, sum, acc_lo[WIDTH-1:1]};
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        product_q   <= '0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    product_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier against a plain a*b reference.
module tb_shift_add_multiplier;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_add_multiplier_if bus();

    shift_add_multiplier #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the cycle index (handshake = 0) at which out_valid is seen.
    task automatic wait_done(input bit noise, output int k);
        k = 1;
        while (bus.out_valid !== 1'b1 && k < 60) begin
            if (noise) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.a = $urandom;
                bus.b = $urandom;
            end
            step();
            k++;
        end
        if (noise) bus.in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int stall, input bit noise, input string name);
        logic [63:0] exp;
        int k;
        exp = {32'd0, a} * {32'd0, b};
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL %s in_ready before accept: got %b want 1", name, bus.in_ready);
        end
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        bus.out_ready = (stall == 0);
        step();
        bus.in_valid = 1'b0;
        wait_done(noise, k);
        n_vec++;
        if (k !== 33) begin
            n_err++; $display("FAIL %s latency: got %0d want 33", name, k);
        end
        n_vec++;
        if (bus.product !== exp) begin
            n_err++; $display("FAIL %s product: got %h want %h", name, bus.product, exp);
        end
        for (int i = 0; i < stall; i++) begin
            if (noise) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.a = $urandom;
                bus.b = $urandom;
            end
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.product !== exp) begin
                n_err++;
                $display("FAIL %s stall %0d: got v=%b r=%b p=%h want v=1 r=0 p=%h",
                         name, i, bus.out_valid, bus.in_ready, bus.product, exp);
            end
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.product !== exp) begin
            n_err++;
            $display("FAIL %s transfer cycle: got v=%b p=%h want v=1 p=%h",
                     name, bus.out_valid, bus.product, exp);
        end
        step();
        bus.out_ready = 1'b0;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.product !== 64'd0) begin
            n_err++;
            $display("FAIL %s back to idle: got r=%b v=%b p=%h want r=1 v=0 p=0",
                     name, bus.in_ready, bus.out_valid, bus.product);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        step();
        step();
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.product !== 64'd0) begin
            n_err++;
            $display("FAIL reset state: got r=%b v=%b p=%h want r=1 v=0 p=0",
                     bus.in_ready, bus.out_valid, bus.product);
        end
        #2 rst = 1'b0;
        step();
    endtask

    task automatic test_directed();
        run_op(32'd3, 32'd5, 0, 1'b0, "3x5");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "max x max");
        run_op(32'h8000_0000, 32'd2, 0, 1'b0, "msb x 2");
        run_op(32'd0, 32'h1234_5678, 0, 1'b0, "zero x b");
    endtask

    task automatic test_backpressure();
        run_op(32'd7, 32'd6, 5, 1'b1, "7x6 stall5");
    endtask

    task automatic test_reset_mid();
        bus.a = 32'hDEAD_BEEF;
        bus.b = 32'h0000_1234;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.product !== 64'd0) begin
            n_err++;
            $display("FAIL async abort: got v=%b r=%b p=%h want v=0 r=1 p=0",
                     bus.out_valid, bus.in_ready, bus.product);
        end
        #1 rst = 1'b0;
        step();
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle after abort: got r=%b v=%b want r=1 v=0", bus.in_ready, bus.out_valid);
        end
        run_op(32'd9, 32'd9, 0, 1'b0, "9x9 after reset");
    endtask

    task automatic test_random();
        logic [31:0] ra, rb;
        for (int n = 0; n < 20; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 7 == 3) ra = 32'hFFFF_FFFF;
            if (n % 5 == 4) rb = 32'hFFFF_FFFF;
            run_op(ra, rb, int'($urandom_range(0, 3)), 1'b1, "random");
        end
    endtask

    // in_valid held high: each new operation is accepted the cycle IDLE returns.
    task automatic test_back_to_back();
        logic [31:0] ra, rb;
        logic [63:0] exp;
        int k;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            n_vec++;
            if (bus.in_ready !== 1'b1) begin
                n_err++; $display("FAIL b2b %0d in_ready: got %b want 1", n, bus.in_ready);
            end
            ra = $urandom;
            rb = $urandom;
            exp = {32'd0, ra} * {32'd0, rb};
            bus.a = ra;
            bus.b = rb;
            step();
            bus.a = $urandom;
            bus.b = $urandom;
            wait_done(1'b0, k);
            n_vec++;
            if (k !== 33 || bus.product !== exp) begin
                n_err++;
                $display("FAIL b2b %0d: got lat=%0d p=%h want lat=33 p=%h", n, k, bus.product, exp);
            end
            step();
        end
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b final in_ready: got %b want 1", bus.in_ready);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
